commit_trace_fifo: RTL and testbench

Commit-trace buffer sitting directly downstream of the multicycle MIPS `cpu`: it snoops the CPU's register-file write port and records every architecturally visible register write (PC, destination register, value) into a FIFO. A consumer (testbench checker, or a future UART dumper) drains entries through a valid/ready handshake. This replaces ad-hoc hierarchical peeks at `regfile0` with an ordered, cycle-independent retirement log.

---
 rtl/commit_trace_fifo_if.sv | 46 ++++
 rtl/commit_trace_fifo.sv | 101 ++++++++++
 tb/tb_commit_trace_fifo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_fifo_if.sv
// ============================================================================
//  Module      : commit_trace_fifo_if
//  Description : Bundle between the CPU register-file write port, the commit
//                trace FIFO and its consumer.
//                Producer side : rf_we, rf_waddr, rf_wdata, rf_pc
//                Consumer side : trace_valid/trace_ready handshake with
//                                trace_pc, trace_addr, trace_data
//                Status        : count, full, dropped, commits
//                master modport = CPU/consumer side, slave modport = FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface commit_trace_fifo_if #(
    parameter int AW = 4
);
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [31:0]   rf_pc;

    logic          trace_valid;
    logic          trace_ready;
    logic [31:0]   trace_pc;
    logic [4:0]    trace_addr;
    logic [31:0]   trace_data;

    logic [AW:0]   count;
    logic          full;
    logic [15:0]   dropped;
    logic [31:0]   commits;

    modport master (
        output rf_we, rf_waddr, rf_wdata, rf_pc, trace_ready,
        input  trace_valid, trace_pc, trace_addr, trace_data,
        input  count, full, dropped, commits
    );

    modport slave (
        input  rf_we, rf_waddr, rf_wdata, rf_pc, trace_ready,
        output trace_valid, trace_pc, trace_addr, trace_data,
        output count, full, dropped, commits
    );
endinterface

`default_nettype wire

// File: rtl/commit_trace_fifo.sv
// ============================================================================
//  Module      : commit_trace_fifo
//  Description : Retirement log for the multicycle MIPS cpu. Snoops the
//                register-file write port and queues every write to a
//                non-zero register as {pc, reg, value}. A consumer drains the
//                queue through a show-ahead valid/ready handshake.
//  Ports       : clk   - clock, all state updates on the rising edge
//                reset - synchronous active-high reset
//                bus   - commit_trace_fifo_if.slave (rf_* in, trace_* out,
//                        count/full/dropped/commits status out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    commit_trace_fifo_if.slave     bus
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
    localparam int          c_ew    = 32 + 5 + 32;   // {pc, addr, data}

    // Entry storage; contents are never reset, validity comes from r_count.
    logic [c_ew-1:0] r_mem [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [15:0]     r_dropped;
    logic [31:0]     r_commits;

    logic            w_qual;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [c_ew-1:0] w_head;

    // Writes to $zero are architecturally invisible and are ignored.
    assign w_qual = bus.rf_we && (bus.rf_waddr != 5'd0);
    assign w_full = (r_count == c_depth);
    // trace_valid is r_count != 0, so ready while empty never pops.
    assign w_pop  = (r_count != '0) && bus.trace_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push = w_qual && (!w_full || w_pop);
    assign w_drop = w_qual && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.rf_pc, bus.rf_waddr, bus.rf_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dropped <= '0;
            r_commits <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end
            if (w_qual) begin
                r_commits <= r_commits + 32'd1;
            end
        end
    end

    // Show-ahead head; zeroed when empty so stale array contents never leak.
    assign w_head = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

    assign bus.trace_valid = (r_count != '0);
    assign bus.trace_pc    = w_head[68:37];
    assign bus.trace_addr  = w_head[36:32];
    assign bus.trace_data  = w_head[31:0];
    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.dropped     = r_dropped;
    assign bus.commits     = r_commits;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
// ============================================================================
//  Module      : tb_commit_trace_fifo
//  Description : Directed self-checking bench for commit_trace_fifo
//                (DEPTH=16). Inputs change and outputs are sampled 1 time
//                unit after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_trace_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    commit_trace_fifo_if #(.AW(AW)) bus ();

    commit_trace_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        bus.rf_we    = 1'b1;
        bus.rf_waddr = a;
        bus.rf_wdata = d;
        bus.rf_pc    = pc;
    endtask

    task automatic idle_write();
        bus.rf_we    = 1'b0;
        bus.rf_waddr = 5'd0;
        bus.rf_wdata = 32'd0;
        bus.rf_pc    = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic check_single_write();
        drive_write(5'd8, 32'd42, 32'h10);
        step();
        idle_write();
        check("single_valid", 32'(bus.trace_valid), 32'd1);
        check("single_addr",  32'(bus.trace_addr),  32'd8);
        check("single_data",  bus.trace_data,       32'd42);
        check("single_pc",    bus.trace_pc,         32'd16);
        check("single_count", 32'(bus.count),       32'd1);
        bus.trace_ready = 1'b1;
        step();
        bus.trace_ready = 1'b0;
        check("pop_valid", 32'(bus.trace_valid), 32'd0);
        check("pop_addr",  32'(bus.trace_addr),  32'd0);
        check("pop_data",  bus.trace_data,       32'd0);
        check("pop_pc",    bus.trace_pc,         32'd0);
        check("pop_count", 32'(bus.count),       32'd0);
    endtask

    initial begin
        idle_write();
        bus.trace_ready = 1'b0;

        // ---- reset and idle ------------------------------------------------
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_valid",   32'(bus.trace_valid), 32'd0);
            check("idle_count",   32'(bus.count),       32'd0);
        end
        check("rst_full",    32'(bus.full),       32'd0);
        check("rst_dropped", 32'(bus.dropped),    32'd0);
        check("rst_commits", bus.commits,         32'd0);
        check("rst_data",    bus.trace_data,      32'd0);
        check("rst_pc",      bus.trace_pc,        32'd0);
        check("rst_addr",    32'(bus.trace_addr), 32'd0);

        // write to $zero is ignored
        drive_write(5'd0, 32'hDEAD, 32'h40);
        step();
        idle_write();
        check("zero_count",   32'(bus.count), 32'd0);
        check("zero_commits", bus.commits,    32'd0);
        check("zero_valid",   32'(bus.trace_valid), 32'd0);

        // ---- single write / single pop -------------------------------------
        check_single_write();
        check("single_commits", bus.commits, 32'd1);

        // ---- fill, overflow, drain -----------------------------------------
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_write(5'(i), 32'(i), 32'h100 + 32'(4 * i));
            step();
        end
        check("fill_full",  32'(bus.full),  32'd1);
        check("fill_count", 32'(bus.count), 32'd16);
        drive_write(5'd17, 32'd17, 32'h144);
        step();
        idle_write();
        check("ovf_dropped", 32'(bus.dropped), 32'd1);
        check("ovf_commits", bus.commits,      32'd17);
        check("ovf_count",   32'(bus.count),   32'd16);
        check("head_pc",     bus.trace_pc,     32'h104);
        check("head_addr",   32'(bus.trace_addr), 32'd1);
        bus.trace_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain_data", bus.trace_data, 32'(i));
            step();
        end
        bus.trace_ready = 1'b0;
        check("drain_valid", 32'(bus.trace_valid), 32'd0);
        check("drain_count", 32'(bus.count),       32'd0);
        check("drain_full",  32'(bus.full),        32'd0);

        // ---- full with simultaneous push and pop ---------------------------
        for (int i = 1; i <= DEPTH; i++) begin
            drive_write(5'(i), 32'(i), 32'h200 + 32'(4 * i));
            step();
        end
        drive_write(5'd5, 32'd100, 32'h300);
        bus.trace_ready = 1'b1;
        step();
        idle_write();
        bus.trace_ready = 1'b0;
        check("pp_count",   32'(bus.count),   32'd16);
        check("pp_full",    32'(bus.full),    32'd1);
        check("pp_dropped", 32'(bus.dropped), 32'd1);
        check("pp_head",    bus.trace_data,   32'd2);
        check("pp_commits", bus.commits,      32'd34);
        bus.trace_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            check("pp_drain", bus.trace_data, (k < DEPTH - 1) ? 32'(k + 2) : 32'd100);
            step();
        end
        bus.trace_ready = 1'b0;
        check("pp_empty", 32'(bus.count), 32'd0);

        // ---- streaming across pointer wrap ---------------------------------
        do_reset();
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_write(5'((i % 31) + 1), 32'd1000 + 32'(i), 32'h400 + 32'(4 * i));
            step();
            check("stream_data",  bus.trace_data, 32'd1000 + 32'(i));
            check("stream_count", 32'(bus.count), 32'd1);
        end
        idle_write();
        step();
        bus.trace_ready = 1'b0;
        check("stream_end_count", 32'(bus.count),   32'd0);
        check("stream_dropped",   32'(bus.dropped), 32'd0);
        check("stream_commits",   bus.commits,      32'd40);

        // ---- reset mid-stream ----------------------------------------------
        for (int i = 0; i < 21; i++) begin
            drive_write(5'd9, 32'd500 + 32'(i), 32'h800);
            step();
        end
        idle_write();
        check("mid_dropped", 32'(bus.dropped), 32'd5);
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        bus.trace_ready = 1'b0;
        check("mid_count", 32'(bus.count),  32'd5);
        check("mid_head",  bus.trace_data,  32'd511);
        reset = 1'b1;
        drive_write(5'd3, 32'd7, 32'h900);
        step();
        reset = 1'b0;
        idle_write();
        check("mrst_count",   32'(bus.count),       32'd0);
        check("mrst_valid",   32'(bus.trace_valid), 32'd0);
        check("mrst_dropped", 32'(bus.dropped),     32'd0);
        check("mrst_commits", bus.commits,          32'd0);
        check("mrst_data",    bus.trace_data,       32'd0);
        step();
        check("mrst_lost", 32'(bus.count), 32'd0);
        check_single_write();
        check("post_commits", bus.commits, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
